usb_frame_assembler: RTL

Upstream stage of the AXI USB slave's data-steering selector. Parses the byte stream from the USB receive path into write frames of header, address and payload. Assembles each payload into one 32-bit write word, flagged for either the register file or memory. Presents one word at a time, with address and target flag, on a valid/ready write port that feeds the selector.

---
 rtl/usb_frame_assembler.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/usb_frame_assembler.sv
// Parses USB receive bytes into header/address/payload write frames and presents
// one assembled 32-bit word at a time on a valid/ready write port.
module usb_frame_assembler #(
  parameter int ADDR_W     = 32,
  parameter int ADDR_BYTES = 4,
  parameter int REG_BYTES  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic              wr_reg_mem,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              frame_done,
  output logic              busy
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t              state_r;
  state_t              next_s;
  logic                reg_mem_r;
  logic [6:0]          words_left_r;
  logic [CNT_W-1:0]    byte_cnt_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [31:0]         data_r;
  logic                frame_done_r;

  logic                accept_s;
  logic                addr_last_s;
  logic                data_last_s;
  logic [CNT_W-1:0]    bpw_s;
  logic [ADDR_W-1:0]   addr_ins_s;
  logic [31:0]         data_ins_s;
  logic [ADDR_W-1:0]   addr_step_s;

  // Handshake and status outputs are pure decodes of the state register.
  assign rx_ready   = (state_r != OUT);
  assign wr_valid   = (state_r == OUT);
  assign busy       = (state_r != IDLE);
  assign wr_reg_mem = reg_mem_r;
  assign wr_addr    = addr_r;
  assign wr_data    = data_r;
  assign frame_done = frame_done_r;

  assign accept_s    = rx_valid & rx_ready;
  assign bpw_s       = reg_mem_r ? CNT_W'(REG_BYTES) : CNT_W'(4);
  assign addr_last_s = (byte_cnt_r == CNT_W'(ADDR_BYTES - 1));
  assign data_last_s = (byte_cnt_r == (bpw_s - CNT_W'(1)));
  assign addr_step_s = reg_mem_r ? ADDR_W'(1) : ADDR_W'(4);

  // Address byte insertion; bytes landing above ADDR_W are dropped.
  always_comb begin
    addr_ins_s = addr_r;
    for (int k = 0; k < ADDR_W; k++) begin
      if ((k / 8) == int'(byte_cnt_r)) begin
        addr_ins_s[k] = rx_data[k % 8];
      end else begin
        addr_ins_s[k] = addr_r[k];
      end
    end
  end

  // Payload byte insertion; the first byte of a word clears the upper bits.
  always_comb begin
    data_ins_s = data_r;
    case (byte_cnt_r[1:0])
      2'd0:    data_ins_s        = {24'h00_0000, rx_data};
      2'd1:    data_ins_s[15:8]  = rx_data;
      2'd2:    data_ins_s[23:16] = rx_data;
      2'd3:    data_ins_s[31:24] = rx_data;
      default: data_ins_s        = data_r;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && (rx_data[6:0] != 7'd0)) begin
          next_s = ADDR;
        end else begin
          next_s = IDLE;
        end
      end
      ADDR: begin
        if (accept_s && addr_last_s) begin
          next_s = DATA;
        end else begin
          next_s = ADDR;
        end
      end
      DATA: begin
        if (accept_s && data_last_s) begin
          next_s = OUT;
        end else begin
          next_s = DATA;
        end
      end
      OUT: begin
        if (wr_ready) begin
          next_s = (words_left_r == 7'd1) ? IDLE : DATA;
        end else begin
          next_s = OUT;
        end
      end
      default: next_s = IDLE;
    endcase
  end

  // Frame datapath: header latch, address/payload assembly, post-transfer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_mem_r    <= 1'b0;
      words_left_r <= 7'd0;
      byte_cnt_r   <= '0;
      addr_r       <= '0;
      data_r       <= 32'h0000_0000;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            reg_mem_r    <= rx_data[7];
            words_left_r <= rx_data[6:0];
            byte_cnt_r   <= '0;
          end
        end
        ADDR: begin
          if (accept_s) begin
            addr_r     <= addr_ins_s;
            byte_cnt_r <= addr_last_s ? '0 : (byte_cnt_r + CNT_W'(1));
          end
        end
        DATA: begin
          if (accept_s) begin
            data_r     <= data_ins_s;
            byte_cnt_r <= data_last_s ? '0 : (byte_cnt_r + CNT_W'(1));
          end
        end
        OUT: begin
          if (wr_ready) begin
            addr_r       <= addr_r + addr_step_s;
            words_left_r <= words_left_r - 7'd1;
            byte_cnt_r   <= '0;
            frame_done_r <= (words_left_r == 7'd1);
          end
        end
        default: begin
          byte_cnt_r <= '0;
        end
      endcase
    end
  end

endmodule
